mux_scan_sequencer: RTL

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

---
 rtl/mux_scan_pkg.sv | 19 +
 rtl/mux_scan_sequencer_if.sv | 28 ++
 rtl/mux_scan_sel.sv | 28 ++
 rtl/mux_scan_sequencer.sv | 101 ++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and defaults for the mux scan sequencer
package mux_scan_pkg;

    localparam int DEF_N_CH = 4;
    localparam int DEF_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_PRESENT,
        ST_DWELL
    } state_t;

    // Channel index width, never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - sample output handshake bundle
interface mux_scan_sequencer_if
    import mux_scan_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int SEL_W = sel_width(DEF_N_CH)
);

    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - channel slice selection with range check
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int  N_CH  = DEF_N_CH,
    parameter int  W     = DEF_W,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH*W-1:0] din,
    input  logic [SEL_W-1:0]  idx,
    output logic [W-1:0]      data,
    output logic [SEL_W-1:0]  ch,
    output logic              range_err
);

    // Out-of-range indices fall back to channel 0 and raise range_err
    always_comb begin
        range_err = (int'(idx) >= N_CH);
        ch        = range_err ? '0 : idx;
        data      = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == SEL_W'(i)) begin
                data = din[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - manual/round-robin channel sampler with ready/valid output
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int  N_CH  = DEF_N_CH,
    parameter int  W     = DEF_W,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [7:0]           dwell,
    input  logic [N_CH*W-1:0]    din,
    output logic                 sel_err,
    mux_scan_sequencer_if.master out_if
);

    state_t           state;
    logic [SEL_W-1:0] scan_ptr;
    logic [7:0]       dwell_cnt;
    logic             cap_mode;
    logic [SEL_W-1:0] idx;
    logic [W-1:0]     sel_data;
    logic [SEL_W-1:0] sel_ch;
    logic             range_err;

    assign idx = mode ? scan_ptr : sel;

    mux_scan_sel #(
        .N_CH (N_CH),
        .W    (W)
    ) u_sel (
        .din       (din),
        .idx       (idx),
        .data      (sel_data),
        .ch        (sel_ch),
        .range_err (range_err)
    );

    // scan_ptr is always in range, so only a bad manual sel can flag here
    assign sel_err = (state == ST_CAPTURE) && range_err;

    // Sequencer FSM: capture, hold until accepted, optional dwell between scan samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            scan_ptr         <= '0;
            dwell_cnt        <= '0;
            cap_mode         <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_ch    <= '0;
            out_if.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    out_if.out_valid <= 1'b0;
                    if (en) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    out_if.out_data  <= sel_data;
                    out_if.out_ch    <= sel_ch;
                    out_if.out_valid <= 1'b1;
                    cap_mode         <= mode;
                    state            <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (out_if.out_ready) begin
                        out_if.out_valid <= 1'b0;
                        // Only a sample taken in scan mode moves the scan pointer
                        if (cap_mode) begin
                            scan_ptr <= (scan_ptr == SEL_W'(N_CH - 1)) ? '0 : scan_ptr + 1'b1;
                        end
                        if (!en) begin
                            state <= ST_IDLE;
                        end else if (!mode || (dwell == 8'd0)) begin
                            state <= ST_CAPTURE;
                        end else begin
                            dwell_cnt <= dwell - 8'd1;
                            state     <= ST_DWELL;
                        end
                    end
                end
                ST_DWELL: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (dwell_cnt == 8'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        dwell_cnt <= dwell_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
